mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-port memory (ready handshake) between the core's instruction-fetch
//   requester (I) and data load/store requester (D). Sits between minuteCore and a unified
//   memory model; one transaction in flight at a time. D has priority; a burst counter
//   bounds I starvation. A watchdog aborts transactions whose mem_ready never arrives.
// PARAMETERS
//   ADDR_W       32   address width
//   DATA_W       32   data width
//   MAX_D_BURST  4    consecutive D grants allowed while I pending before I is forced (>=1)
//   TIMEOUT      64   BUSY cycles without mem_ready before abort (>=2)
// PORTS
//   clk           in   1       clock; all logic on posedge
//   reset         in   1       synchronous, active-high
//   i_req_valid   in   1       fetch request; held with i_req_addr stable until i_resp_valid
//   i_req_addr    in   ADDR_W  fetch address
//   i_resp_valid  out  1       one-cycle pulse: fetch complete
//   i_resp_data   out  DATA_W  fetched word, valid while i_resp_valid=1
//   d_req_rd      in   1       load request; held until d_resp_valid
//   d_req_wr      in   1       store request; held until d_resp_valid
//   d_req_addr    in   ADDR_W  load/store address
//   d_req_size    in   2       store size code, passed through to mem_w_size
//   d_req_wdata   in   DATA_W  store data
//   d_resp_valid  out  1       one-cycle pulse: load/store complete
//   d_resp_rdata  out  DATA_W  load data; updated on D reads only
//   resp_err      out  1       pulses with *_resp_valid when transaction timed out
//   mem_addr      out  ADDR_W  memory address
//   mem_r_enable  out  1       memory read strobe, held until mem_ready
//   mem_w_enable  out  1       memory write strobe, held until mem_ready
//   mem_w_size    out  2       memory write size
//   mem_w_data    out  DATA_W  memory write data
//   mem_r_data    in   DATA_W  memory read data, sampled when mem_ready=1
//   mem_ready     in   1       memory completes current access this cycle
// BEHAVIOUR
//   FSM states IDLE, BUSY_I, BUSY_D, RESP. All outputs registered.
//   Reset: state=IDLE; all mem_* and resp outputs 0; burst and timeout counters 0.
//     Reset mid-transaction drops it silently: no resp pulse, enables 0 next cycle.
//   IDLE: d_pend=d_req_rd|d_req_wr. Grant: d_pend & !(i_req_valid & burst==MAX_D_BURST)
//     -> BUSY_D; else i_req_valid -> BUSY_I; else stay. On grant latch addr/size/wdata to mem_*.
//   Burst counter: +1 on D grant while i_req_valid=1 (saturates at MAX_D_BURST); cleared
//     on any I grant or on D grant with i_req_valid=0.
//   d_req_rd & d_req_wr both set: illegal; treated as write (mem_r_enable=0).
//   BUSY_x: I or D-read asserts mem_r_enable; D-write asserts mem_w_enable; mem_w_size/data
//     valid on writes only. Timeout counter starts at 0 on entry, +1 each cycle mem_ready=0.
//     mem_ready=1 -> RESP, capture mem_r_data for reads, drop enables.
//     Counter reaches TIMEOUT-1 with mem_ready=0 -> RESP with error flag, enables dropped,
//     data output not updated.
//   RESP: exactly one cycle; i_resp_valid or d_resp_valid=1 for granted side; resp_err=1 if
//     aborted; next state IDLE unconditionally. Requester drops request on seeing resp.
//   Latency: request in IDLE cycle N -> enable cycles N+1..; zero-wait memory gives resp
//     at N+2; max throughput one access per 3 cycles (IDLE bubble guaranteed).
//   i_resp_data/d_resp_rdata hold last captured value between responses (0 after reset).
//   Request changes while granted are ignored; latched values are used.
// TESTING
//   I-only fetch addr 0x10, mem_ready same cycle, mem_r_data=0xDEADBEEF -> i_resp_valid at
//     cycle 2, i_resp_data=0xDEADBEEF, d_resp_valid stays 0.
//   D write addr 0x40 size 2'b10 data 0x1234 with 3 wait cycles -> mem_w_enable high 4
//     cycles, mem_r_enable 0, d_resp_valid pulses once, d_resp_rdata unchanged.
//   I and D requests continuously asserted, MAX_D_BURST=4 -> grant order D,D,D,D,I, repeat;
//     I never waits more than 4 transactions.
//   mem_ready held 0, TIMEOUT=64 -> enable drops after 64 BUSY cycles, resp_valid and
//     resp_err pulse together next cycle, FSM back to IDLE.
//   reset asserted in BUSY_D -> next cycle all enables 0, no resp pulse; new I request then
//     served normally with burst counter 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory signals around mem_arbiter.
// The slave view belongs to the arbiter; the master view is the environment (core + memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;
  logic              d_req_rd;
  logic              d_req_wr;
  logic [ADDR_W-1:0] d_req_addr;
  logic [1:0]        d_req_size;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [1:0]        mem_w_size;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_ready;

  modport slave (
    input  i_req_valid, i_req_addr, d_req_rd, d_req_wr, d_req_addr, d_req_size,
           d_req_wdata, mem_r_data, mem_ready,
    output i_resp_valid, i_resp_data, d_resp_valid, d_resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
  );

  modport master (
    output i_req_valid, i_req_addr, d_req_rd, d_req_wr, d_req_addr, d_req_size,
           d_req_wdata, mem_r_data, mem_ready,
    input  i_resp_valid, i_resp_data, d_resp_valid, d_resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_w_size, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D has priority, a burst counter forces I after
// MAX_D_BURST back-to-back D grants, and a watchdog aborts stuck accesses.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int BST_W = $clog2(MAX_D_BURST + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [BST_W-1:0] BST_MAX  = BST_W'(MAX_D_BURST);

  state_e            state_q, state_d;
  logic [BST_W-1:0]  burst_q, burst_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              r_en_q, r_en_d;
  logic              w_en_q, w_en_d;
  logic [1:0]        w_size_q, w_size_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              i_rv_q, i_rv_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_rv_q, d_rv_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic d_pend, grant_d, grant_i, tmo_hit;

  assign d_pend  = bus.d_req_rd | bus.d_req_wr;
  assign grant_d = d_pend & ~(bus.i_req_valid & (burst_q == BST_MAX));
  assign grant_i = ~grant_d & bus.i_req_valid;
  assign tmo_hit = ~bus.mem_ready & (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      r_en_q    <= 1'b0;
      w_en_q    <= 1'b0;
      w_size_q  <= '0;
      w_data_q  <= '0;
      i_rv_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rv_q    <= 1'b0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      r_en_q    <= r_en_d;
      w_en_q    <= w_en_d;
      w_size_q  <= w_size_d;
      w_data_q  <= w_data_d;
      i_rv_q    <= i_rv_d;
      i_rdata_q <= i_rdata_d;
      d_rv_q    <= d_rv_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: if (bus.mem_ready || tmo_hit) state_d = RESP;
      RESP:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    r_en_d    = r_en_q;
    w_en_d    = w_en_q;
    w_size_d  = w_size_q;
    w_data_d  = w_data_q;
    i_rv_d    = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rv_d    = 1'b0;
    d_rdata_d = d_rdata_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant_d) begin
          // Simultaneous rd and wr is illegal; the write wins.
          addr_d   = bus.d_req_addr;
          w_en_d   = bus.d_req_wr;
          r_en_d   = ~bus.d_req_wr;
          w_size_d = bus.d_req_wr ? bus.d_req_size  : 2'b00;
          w_data_d = bus.d_req_wr ? bus.d_req_wdata : '0;
          if (!bus.i_req_valid)       burst_d = '0;
          else if (burst_q != BST_MAX) burst_d = burst_q + 1'b1;
        end else if (grant_i) begin
          addr_d   = bus.i_req_addr;
          r_en_d   = 1'b1;
          w_en_d   = 1'b0;
          w_size_d = 2'b00;
          w_data_d = '0;
          burst_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready || tmo_hit) begin
          r_en_d = 1'b0;
          w_en_d = 1'b0;
          err_d  = tmo_hit;
          if (state_q == BUSY_I) begin
            i_rv_d = 1'b1;
            if (bus.mem_ready) i_rdata_d = bus.mem_r_data;
          end else begin
            d_rv_d = 1'b1;
            if (bus.mem_ready && r_en_q) d_rdata_d = bus.mem_r_data;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_r_enable = r_en_q;
  assign bus.mem_w_enable = w_en_q;
  assign bus.mem_w_size   = w_size_q;
  assign bus.mem_w_data   = w_data_q;
  assign bus.i_resp_valid = i_rv_q;
  assign bus.i_resp_data  = i_rdata_q;
  assign bus.d_resp_valid = d_rv_q;
  assign bus.d_resp_rdata = d_rdata_q;
  assign bus.resp_err     = err_q;
endmodule
